// File: rtl/sd_wr_sector_feeder_if.sv
// Bundle of the upstream word stream, flush control and SD controller write
// handshake used by the sector feeder. The feeder takes the slave view; the
// application/controller side takes the master view.
interface sd_wr_sector_feeder_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        flush;
  logic        sd_init_done;
  logic        wr_busy;
  logic        wr_req;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic [15:0] wr_data;
  logic        sec_done;
  logic [31:0] sec_count;
  logic        err_underflow;

  modport slave (
    input  in_valid, in_data, flush, sd_init_done, wr_busy, wr_req,
    output in_ready, wr_start_en, wr_sec_addr, wr_data, sec_done, sec_count,
           err_underflow
  );

  modport master (
    output in_valid, in_data, flush, sd_init_done, wr_busy, wr_req,
    input  in_ready, wr_start_en, wr_sec_addr, wr_data, sec_done, sec_count,
           err_underflow
  );
endinterface

// File: rtl/sd_wr_sector_feeder.sv
// SD write-path sector feeder: buffers a 16-bit word stream in a FWFT FIFO and,
// whenever a whole sector (or a flushed, padded partial sector) is available,
// runs one sector write against the SD SPI controller.
//
// Padding bookkeeping: pad_left counts pad words still owed, pre_pad counts the
// FIFO words that sit ahead of that padding. At START the number of FIFO words
// this sector may consume (fifo_left) is fixed, so words pushed during a
// transfer, or after a flush, always land behind the current sector.
module sd_wr_sector_feeder #(
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned SEC_WORDS = 256,
  parameter logic [31:0] START_SEC = 32'd0,
  parameter logic [15:0] PAD_WORD  = 16'hFFFF
) (
  input  logic                  clk_sd,
  input  logic                  reset_n,
  sd_wr_sector_feeder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;
  localparam int unsigned CW = $clog2(SEC_WORDS + 1);

  localparam logic [FW-1:0] SEC_F   = FW'(SEC_WORDS);
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);
  localparam logic [CW-1:0] SEC_C   = CW'(SEC_WORDS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_XFER      = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [FW-1:0] pre_pad_q, pre_pad_d;
  logic [CW-1:0] pad_left_q, pad_left_d;
  logic [CW-1:0] fifo_left_q, fifo_left_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic          flush_pend_q, flush_pend_d;
  logic          in_ready_q, in_ready_d;
  logic          start_en_q, start_en_d;
  logic [31:0]   sec_addr_q, sec_addr_d;
  logic          sec_done_q, sec_done_d;
  logic [31:0]   sec_count_q, sec_count_d;
  logic          err_q, err_d;

  logic          push_s;
  logic          pop_s;
  logic          flush_req_s;
  logic [FW-1:0] rem_s;
  logic [15:0]   wr_data_s;

  assign push_s      = bus.in_valid && in_ready_q;
  assign flush_req_s = bus.flush || flush_pend_q;
  assign rem_s       = fill_q % SEC_F;

  // Sector write sequencing, flush/padding accounting and status updates.
  always_comb begin
    state_d      = state_q;
    pad_left_d   = pad_left_q;
    pre_pad_d    = pre_pad_q;
    fifo_left_d  = fifo_left_q;
    word_cnt_d   = word_cnt_q;
    flush_pend_d = flush_pend_q;
    sec_addr_d   = sec_addr_q;
    sec_count_d  = sec_count_q;
    err_d        = err_q;
    start_en_d   = 1'b0;
    sec_done_d   = 1'b0;
    pop_s        = 1'b0;

    // A flush seen outside IDLE is remembered and evaluated once back in IDLE.
    if ((state_q != S_IDLE) && bus.flush) begin
      flush_pend_d = 1'b1;
    end else begin
      flush_pend_d = flush_pend_q;
    end

    if ((state_q != S_IDLE) && !bus.sd_init_done) begin
      // Controller lost init: drop the write, keep FIFO and address untouched.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          flush_pend_d = 1'b0;
          if (flush_req_s && (pad_left_q == '0) && (rem_s != '0)) begin
            pad_left_d = CW'(SEC_F - rem_s);
            pre_pad_d  = fill_q;
          end else begin
            pad_left_d = pad_left_q;
          end
          if (bus.sd_init_done && !bus.wr_busy &&
              ((fill_q >= SEC_F) || (pad_left_q != '0))) begin
            state_d    = S_START;
            start_en_d = 1'b1;
            word_cnt_d = '0;
            // The padded sector only takes the words that preceded the flush.
            if ((pad_left_q != '0) && (pre_pad_q < SEC_F)) begin
              fifo_left_d = CW'(pre_pad_q);
            end else begin
              fifo_left_d = SEC_C;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_START: begin
          state_d = S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (bus.wr_busy) begin
            state_d = S_XFER;
          end else begin
            state_d = S_WAIT_BUSY;
          end
        end
        S_XFER: begin
          if (bus.wr_req) begin
            word_cnt_d = word_cnt_q + CW'(1);
            if (fifo_left_q != '0) begin
              pop_s       = 1'b1;
              fifo_left_d = fifo_left_q - CW'(1);
              if (pad_left_q != '0) begin
                pre_pad_d = pre_pad_q - FW'(1);
              end else begin
                pre_pad_d = pre_pad_q;
              end
            end else if (pad_left_q != '0) begin
              pad_left_d = pad_left_q - CW'(1);
            end else if (fill_q == '0) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
            if (word_cnt_q == (SEC_C - CW'(1))) begin
              state_d = S_WAIT_DONE;
            end else begin
              state_d = S_XFER;
            end
          end else begin
            state_d = S_XFER;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.wr_busy) begin
            state_d     = S_IDLE;
            sec_done_d  = 1'b1;
            sec_addr_d  = sec_addr_q + 32'd1;
            sec_count_d = sec_count_q + 32'd1;
          end else begin
            state_d = S_WAIT_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // FIFO pointer and occupancy updates; in_ready follows the next fill level.
  always_comb begin
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
    in_ready_d = (fill_d < DEPTH_F);
  end

  // First-word-fall-through head, replaced by the pad word while padding/empty.
  always_comb begin
    if ((fill_q != '0) && !((state_q == S_XFER) && (fifo_left_q == '0))) begin
      wr_data_s = mem_q[rd_ptr_q];
    end else begin
      wr_data_s = PAD_WORD;
    end
  end

  // FIFO storage write port; contents need no reset since pointers define validity.
  always_ff @(posedge clk_sd) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // State and status registers with asynchronous reset.
  always_ff @(posedge clk_sd or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      pre_pad_q    <= '0;
      pad_left_q   <= '0;
      fifo_left_q  <= '0;
      word_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      in_ready_q   <= 1'b1;
      start_en_q   <= 1'b0;
      sec_addr_q   <= START_SEC;
      sec_done_q   <= 1'b0;
      sec_count_q  <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      pre_pad_q    <= pre_pad_d;
      pad_left_q   <= pad_left_d;
      fifo_left_q  <= fifo_left_d;
      word_cnt_q   <= word_cnt_d;
      flush_pend_q <= flush_pend_d;
      in_ready_q   <= in_ready_d;
      start_en_q   <= start_en_d;
      sec_addr_q   <= sec_addr_d;
      sec_done_q   <= sec_done_d;
      sec_count_q  <= sec_count_d;
      err_q        <= err_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.wr_start_en   = start_en_q;
  assign bus.wr_sec_addr   = sec_addr_q;
  assign bus.wr_data       = wr_data_s;
  assign bus.sec_done      = sec_done_q;
  assign bus.sec_count     = sec_count_q;
  assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_sd_wr_sector_feeder.sv
// Directed bench for sd_wr_sector_feeder: the bench plays both the upstream
// producer and the SD controller, and checks every read word against a queue
// of hand-determined expected words.
module tb_sd_wr_sector_feeder;

  localparam logic [15:0] PAD = 16'hFFFF;

  logic clk_sd = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  logic [15:0] exp_q [$];

  sd_wr_sector_feeder_if bus ();

  sd_wr_sector_feeder #(
    .DEPTH     (512),
    .SEC_WORDS (256),
    .START_SEC (32'd0),
    .PAD_WORD  (16'hFFFF)
  ) dut (
    .clk_sd  (clk_sd),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sd = ~clk_sd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_in_ready"},    bus.in_ready,      64'd1);
    chk({pfx, "_start_en"},    bus.wr_start_en,   64'd0);
    chk({pfx, "_sec_addr"},    bus.wr_sec_addr,   64'd0);
    chk({pfx, "_wr_data"},     bus.wr_data,       64'hFFFF);
    chk({pfx, "_sec_done"},    bus.sec_done,      64'd0);
    chk({pfx, "_sec_count"},   bus.sec_count,     64'd0);
    chk({pfx, "_err"},         bus.err_underflow, 64'd0);
  endtask

  task automatic push_words(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sd);
      bus.in_valid = 1'b1;
      bus.in_data  = base + 16'(i);
      exp_q.push_back(base + 16'(i));
    end
    @(negedge clk_sd);
    bus.in_valid = 1'b0;
  endtask

  task automatic add_pad(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(PAD);
  endtask

  task automatic pulse_flush();
    @(negedge clk_sd);
    bus.flush = 1'b1;
    @(negedge clk_sd);
    bus.flush = 1'b0;
  endtask

  task automatic wait_start(input int budget, input logic [31:0] exp_addr);
    logic found;
    found = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (bus.wr_start_en === 1'b1) begin
        found = 1'b1;
        break;
      end
      if (i < budget) @(negedge clk_sd);
    end
    chk("start_seen", found, 64'd1);
    if (found) begin
      chk("start_addr", bus.wr_sec_addr, exp_addr);
      bus.wr_busy = 1'b1;
      @(negedge clk_sd);
      chk("start_one_cycle", bus.wr_start_en, 64'd0);
    end
  endtask

  task automatic xfer(input int n);
    logic [15:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sd);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = PAD;
      chk("wr_data", bus.wr_data, e);
      bus.wr_req = 1'b1;
    end
    @(negedge clk_sd);
    bus.wr_req = 1'b0;
  endtask

  task automatic finish_sector(input logic [31:0] exp_addr, input logic [31:0] exp_cnt);
    logic found;
    found = 1'b0;
    bus.wr_busy = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (bus.sec_done === 1'b1) begin
        found = 1'b1;
        break;
      end
      if (i < 10) @(negedge clk_sd);
    end
    chk("sec_done_seen", found, 64'd1);
    chk("addr_after_done", bus.wr_sec_addr, exp_addr);
    chk("count_after_done", bus.sec_count, exp_cnt);
    @(negedge clk_sd);
    chk("sec_done_one_cycle", bus.sec_done, 64'd0);
  endtask

  task automatic no_start(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sd);
      if (bus.wr_start_en === 1'b1) seen++;
    end
    chk("no_start", seen, 64'd0);
  endtask

  // Watchdog so a stuck design can never hang the run.
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_data      = 16'h0000;
    bus.flush        = 1'b0;
    bus.sd_init_done = 1'b0;
    bus.wr_busy      = 1'b0;
    bus.wr_req       = 1'b0;
    repeat (3) @(negedge clk_sd);
    chk_reset("rst");
    reset_n = 1'b1;
    bus.sd_init_done = 1'b1;

    // Full sector with an idle controller.
    push_words(256, 16'h0000);
    wait_start(10, 32'd0);
    xfer(256);
    finish_sector(32'd1, 32'd1);

    // Stalled controller: FIFO fills to 512 and refuses a 513th word.
    bus.wr_busy = 1'b1;
    push_words(512, 16'h1000);
    chk("in_ready_full", bus.in_ready, 64'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hDEAD;
    @(negedge clk_sd);
    bus.in_valid = 1'b0;
    chk("stall_no_start", bus.wr_start_en, 64'd0);
    bus.wr_busy = 1'b0;
    wait_start(4, 32'd1);
    xfer(256);
    chk("in_ready_after_pop", bus.in_ready, 64'd1);
    bus.wr_req = 1'b1;            // extra requests after the sector are ignored
    @(negedge clk_sd);
    @(negedge clk_sd);
    bus.wr_req = 1'b0;
    finish_sector(32'd2, 32'd2);
    wait_start(4, 32'd2);
    xfer(256);
    finish_sector(32'd3, 32'd3);

    // Partial sector flush: 100 data words then 156 pad words.
    push_words(100, 16'h2000);
    pulse_flush();
    add_pad(156);
    wait_start(4, 32'd3);
    xfer(256);
    finish_sector(32'd4, 32'd4);
    chk("empty_in_ready", bus.in_ready, 64'd1);
    chk("empty_wr_data", bus.wr_data, 64'hFFFF);
    pulse_flush();                // aligned fill: flush does nothing
    no_start(6);

    // Controller not initialised: no start until sd_init_done rises.
    bus.sd_init_done = 1'b0;
    push_words(256, 16'h3000);
    no_start(6);
    bus.sd_init_done = 1'b1;
    wait_start(2, 32'd4);
    xfer(256);
    finish_sector(32'd5, 32'd5);

    // Abort mid padded sector, then restart and run into underflow.
    push_words(10, 16'h4000);
    pulse_flush();
    add_pad(246);
    wait_start(4, 32'd5);
    xfer(20);
    bus.sd_init_done = 1'b0;
    bus.wr_busy      = 1'b0;
    repeat (3) @(negedge clk_sd);
    chk("abort_count", bus.sec_count, 64'd5);
    chk("abort_addr", bus.wr_sec_addr, 64'd5);
    bus.sd_init_done = 1'b1;
    wait_start(4, 32'd5);
    xfer(236);
    chk("err_before_underflow", bus.err_underflow, 64'd0);
    add_pad(20);
    xfer(20);
    chk("err_after_underflow", bus.err_underflow, 64'd1);
    finish_sector(32'd6, 32'd6);
    chk("err_sticky", bus.err_underflow, 64'd1);

    // Asynchronous reset in the middle of a transfer (after word 37).
    push_words(256, 16'h5000);
    wait_start(4, 32'd6);
    xfer(37);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("midrst");
    bus.wr_busy = 1'b0;
    bus.wr_req  = 1'b0;
    exp_q.delete();
    @(negedge clk_sd);
    reset_n = 1'b1;
    push_words(256, 16'h6000);
    wait_start(4, 32'd0);
    xfer(256);
    finish_sector(32'd1, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
